// File: rtl/risc_v_pipeline_pkg.sv
// Shared types for the fetch/MEM memory port arbiter.
`include "risc_v_pipeline_define.svh"

package risc_v_pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    typedef logic [1:0] gnt_t;

    localparam gnt_t GNT_NONE = 2'b00;
    localparam gnt_t GNT_I    = 2'b01;
    localparam gnt_t GNT_D    = 2'b10;

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts back-to-back data grants made while a fetch waits;
// force_if asks the arbiter to serve the fetch next.
`include "risc_v_pipeline_define.svh"

module arb_starve_cnt #(
    parameter int MAX_D_RUN = `RV_MAX_D_RUN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic grant_d,
    input  logic grant_i,
    input  logic if_pending,
    output logic force_if
);

    localparam logic [2:0] RUN_MAX = 3'(MAX_D_RUN);

    logic [2:0] run_cnt_q;
    logic [2:0] run_cnt_d;

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (grant_i) begin
            run_cnt_d = 3'd0;
        end else if (grant_d) begin
            if (!if_pending) begin
                run_cnt_d = 3'd0;
            end else if (run_cnt_q != RUN_MAX) begin
                run_cnt_d = run_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q <= 3'd0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end

    assign force_if = if_pending && (run_cnt_q == RUN_MAX);

endmodule

// File: rtl/risc_v_pipeline_define.svh
// Default tuning knobs for the unified-memory port arbiter.
`ifndef RISC_V_PIPELINE_DEFINE_SVH
`define RISC_V_PIPELINE_DEFINE_SVH

`define RV_MAX_D_RUN 4
`define RV_TIMEOUT   64

`endif

// File: rtl/mem_port_arbiter.sv
// Shares the single-port I/D memory between fetch and MEM,
// with data priority, a starvation guard and an access timeout.
`include "risc_v_pipeline_define.svh"

module mem_port_arbiter
    import risc_v_pipeline_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_D_RUN = `RV_MAX_D_RUN,
    parameter int TIMEOUT   = `RV_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_valid_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_valid_o,
    output logic [DW-1:0] d_rdata_o,
    output logic          err_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ready_i,
    output logic          stall_if_o,
    output logic          stall_mem_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    arb_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          if_valid_q, if_valid_d;
    logic          d_valid_q, d_valid_d;
    logic          err_q, err_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    gnt_t gnt;
    logic force_if;
    logic busy;
    logic finish;
    logic expire;

    arb_starve_cnt #(
        .MAX_D_RUN (MAX_D_RUN)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .grant_d    (gnt == GNT_D),
        .grant_i    (gnt == GNT_I),
        .if_pending (if_req_i),
        .force_if   (force_if)
    );

    // The IDLE cycle that carries a valid pulse still sees the old
    // request held high, so no grant is made in it.
    always_comb begin
        gnt = GNT_NONE;
        if (state_q == IDLE && !(if_valid_q || d_valid_q)) begin
            if (d_req_i && !force_if) begin
                gnt = GNT_D;
            end else if (if_req_i) begin
                gnt = GNT_I;
            end
        end
    end

    assign busy   = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign expire = busy && !mem_ready_i && (to_cnt_q == TO_LAST);
    assign finish = busy && (mem_ready_i || expire);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        to_cnt_d   = to_cnt_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        err_d      = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (gnt == GNT_D) begin
                    state_d  = BUSY_D;
                    addr_d   = d_addr_i;
                    we_d     = d_we_i;
                    wdata_d  = d_wdata_i;
                    to_cnt_d = '0;
                end else if (gnt == GNT_I) begin
                    state_d  = BUSY_I;
                    addr_d   = if_addr_i;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    to_cnt_d = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (finish) begin
                    state_d = IDLE;
                    err_d   = expire;
                    if (state_q == BUSY_I) begin
                        if_valid_d = 1'b1;
                        if (mem_ready_i) begin
                            if_rdata_d = mem_rdata_i;
                        end
                    end else begin
                        d_valid_d = 1'b1;
                        if (mem_ready_i && !we_q) begin
                            d_rdata_d = mem_rdata_i;
                        end
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            to_cnt_q   <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            to_cnt_q   <= to_cnt_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mem_req_o   = busy;
    assign mem_we_o    = (state_q == BUSY_D) && we_q;
    assign mem_addr_o  = busy ? addr_q : '0;
    assign mem_wdata_o = (state_q == BUSY_D) ? wdata_q : '0;

    assign if_valid_o = if_valid_q;
    assign if_rdata_o = if_rdata_q;
    assign d_valid_o  = d_valid_q;
    assign d_rdata_o  = d_rdata_q;
    assign err_o      = err_q;

    // Stalls are held low under reset so every output starts at 0.
    assign stall_mem_o = rst_n && d_req_i && !d_valid_q;
    assign stall_if_o  = (rst_n && if_req_i && !if_valid_q) || stall_mem_o;

endmodule
